// File: rtl/wb_arbiter.sv
// wb_arbiter
// Collects completed results from NUM_PIPES execution pipes and drives NUM_WB
// registered writeback ports. Pipes cannot stall after issue, so each pipe has
// a small FIFO that absorbs results when more pipes complete than there are
// writeback ports. A round-robin pointer arbitrates between pipes.
//
// Ports:
//   clock, reset      clock and synchronous active-high reset
//   flush             discards all buffered and same-cycle incoming results
//   in_valid[p]       pipe p completed a uop this cycle
//   in_rd_valid[p]    completion writes a destination register
//   in_preg/in_rob/in_data   per-pipe fields, pipe p at [p*W +: W]
//   wb_valid[k]       writeback port k carries a result (registered)
//   wb_rd_valid/wb_preg/wb_rob/wb_data   per-port fields, port k at [k*W +: W]
//   stall_pipe[p]     issue must not send a new uop to pipe p
//   overflow          sticky: a completion was dropped on a full FIFO
module wb_arbiter #(
  parameter int NUM_PIPES    = 4,
  parameter int NUM_WB       = 2,
  parameter int DATA_W       = 32,
  parameter int PREG_W       = 6,
  parameter int ROB_W        = 6,
  parameter int FIFO_DEPTH   = 4,
  parameter int STALL_MARGIN = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_PIPES-1:0]        in_valid,
  input  logic [NUM_PIPES-1:0]        in_rd_valid,
  input  logic [NUM_PIPES*PREG_W-1:0] in_preg,
  input  logic [NUM_PIPES*ROB_W-1:0]  in_rob,
  input  logic [NUM_PIPES*DATA_W-1:0] in_data,
  output logic [NUM_WB-1:0]           wb_valid,
  output logic [NUM_WB-1:0]           wb_rd_valid,
  output logic [NUM_WB*PREG_W-1:0]    wb_preg,
  output logic [NUM_WB*ROB_W-1:0]     wb_rob,
  output logic [NUM_WB*DATA_W-1:0]    wb_data,
  output logic [NUM_PIPES-1:0]        stall_pipe,
  output logic                        overflow
);

  // Entry layout: {rd_valid, preg, rob, data}
  localparam int ENT_W = 1 + PREG_W + ROB_W + DATA_W;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int RR_W  = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [ENT_W-1:0] mem_q [NUM_PIPES][FIFO_DEPTH];
  logic [ENT_W-1:0] mem_d [NUM_PIPES][FIFO_DEPTH];
  logic [PTR_W-1:0] head_q  [NUM_PIPES];
  logic [PTR_W-1:0] head_d  [NUM_PIPES];
  logic [PTR_W-1:0] tail_q  [NUM_PIPES];
  logic [PTR_W-1:0] tail_d  [NUM_PIPES];
  logic [CNT_W-1:0] count_q [NUM_PIPES];
  logic [CNT_W-1:0] count_d [NUM_PIPES];
  logic [RR_W-1:0]  rr_q, rr_d;
  logic             overflow_q, overflow_d;
  logic [NUM_WB-1:0] wb_valid_q, wb_valid_d;
  logic [ENT_W-1:0] wb_ent_q [NUM_WB];
  logic [ENT_W-1:0] wb_ent_d [NUM_WB];

  logic [ENT_W-1:0]     in_ent   [NUM_PIPES];
  logic [ENT_W-1:0]     cand_ent [NUM_PIPES];
  logic [NUM_PIPES-1:0] cand_vld;
  logic [NUM_PIPES-1:0] fifo_empty;
  logic [NUM_PIPES-1:0] grant;
  logic [NUM_PIPES-1:0] push;
  logic [NUM_PIPES-1:0] pop;
  int                   n_grant;
  int                   pidx;

  // Candidate per pipe: FIFO head if buffered, else the incoming result (bypass)
  always_comb begin
    for (int p = 0; p < NUM_PIPES; p++) begin
      in_ent[p]     = {in_rd_valid[p], in_preg[p*PREG_W +: PREG_W],
                       in_rob[p*ROB_W +: ROB_W], in_data[p*DATA_W +: DATA_W]};
      fifo_empty[p] = (count_q[p] == '0);
      cand_vld[p]   = !fifo_empty[p] || in_valid[p];
      cand_ent[p]   = fifo_empty[p] ? in_ent[p] : mem_q[p][head_q[p]];
    end
  end

  // Round-robin scan starting at rr; the g-th granted pipe drives port g
  always_comb begin
    grant      = '0;
    rr_d       = rr_q;
    wb_valid_d = '0;
    n_grant    = 0;
    pidx       = 0;
    for (int k = 0; k < NUM_WB; k++) wb_ent_d[k] = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      pidx = (int'(rr_q) + i) % NUM_PIPES;
      for (int p = 0; p < NUM_PIPES; p++) begin
        if (p == pidx && cand_vld[p] && n_grant < NUM_WB) begin
          grant[p] = 1'b1;
          for (int k = 0; k < NUM_WB; k++) begin
            if (k == n_grant) begin
              wb_valid_d[k] = 1'b1;
              wb_ent_d[k]   = cand_ent[p];
            end
          end
          n_grant = n_grant + 1;
          rr_d    = RR_W'((p + 1) % NUM_PIPES);
        end
      end
    end
    // A flush suppresses every grant; rr keeps its value
    if (flush) begin
      grant      = '0;
      rr_d       = rr_q;
      wb_valid_d = '0;
      for (int k = 0; k < NUM_WB; k++) wb_ent_d[k] = '0;
    end
  end

  // Per-pipe FIFO bookkeeping; a bypassed result never enters the FIFO
  always_comb begin
    overflow_d = overflow_q;
    mem_d      = mem_q;
    for (int p = 0; p < NUM_PIPES; p++) begin
      head_d[p]  = head_q[p];
      tail_d[p]  = tail_q[p];
      count_d[p] = count_q[p];
      pop[p]     = grant[p] && !fifo_empty[p];
      push[p]    = in_valid[p] && !(fifo_empty[p] && grant[p]) && !flush;
      // Full with no pop: the result is dropped and the error latches
      if (push[p] && count_q[p] == FULL_CNT && !pop[p]) begin
        push[p]    = 1'b0;
        overflow_d = 1'b1;
      end
      if (push[p]) begin
        mem_d[p][tail_q[p]] = in_ent[p];
        tail_d[p]           = tail_q[p] + PTR_W'(1);
      end
      if (pop[p]) head_d[p] = head_q[p] + PTR_W'(1);
      count_d[p] = count_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
      if (flush) begin
        head_d[p]  = '0;
        tail_d[p]  = '0;
        count_d[p] = '0;
      end
    end
  end

  // Registered state: control and writeback ports
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q       <= '0;
      overflow_q <= 1'b0;
      wb_valid_q <= '0;
      for (int k = 0; k < NUM_WB; k++) wb_ent_q[k] <= '0;
      for (int p = 0; p < NUM_PIPES; p++) begin
        head_q[p]  <= '0;
        tail_q[p]  <= '0;
        count_q[p] <= '0;
      end
    end else begin
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
      wb_valid_q <= wb_valid_d;
      for (int k = 0; k < NUM_WB; k++) wb_ent_q[k] <= wb_ent_d[k];
      for (int p = 0; p < NUM_PIPES; p++) begin
        head_q[p]  <= head_d[p];
        tail_q[p]  <= tail_d[p];
        count_q[p] <= count_d[p];
      end
    end
  end

  // FIFO storage carries data only and is not reset
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Output unpacking and stall hints from registered occupancy
  always_comb begin
    wb_valid = wb_valid_q;
    overflow = overflow_q;
    for (int k = 0; k < NUM_WB; k++) begin
      wb_rd_valid[k]                = wb_ent_q[k][ENT_W-1];
      wb_preg[k*PREG_W +: PREG_W]   = wb_ent_q[k][ROB_W+DATA_W +: PREG_W];
      wb_rob[k*ROB_W +: ROB_W]      = wb_ent_q[k][DATA_W +: ROB_W];
      wb_data[k*DATA_W +: DATA_W]   = wb_ent_q[k][0 +: DATA_W];
    end
    for (int p = 0; p < NUM_PIPES; p++) begin
      stall_pipe[p] = (FIFO_DEPTH - int'(count_q[p])) <= STALL_MARGIN;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter
// Scoreboard bench for wb_arbiter. Two instances share clock and reset:
// dut (NUM_WB=2) and dut1 (NUM_WB=1). Stimulus pushes expected writeback
// entries into per-instance queues in hand-derived retirement order, and
// pushes status expectations (wb_valid, stall_pipe, overflow) tagged with the
// cycle they apply to. A single monitor process on the falling edge pops and
// compares both.
module tb_wb_arbiter;

  typedef logic [46:0] tup_t;  // {port[1:0], rd_valid, preg[5:0], rob[5:0], data[31:0]}

  typedef struct {
    int         cyc;
    int         kind;   // 0: main status, 1: dut1 status, 2: queues drained
    int         id;
    logic [1:0] vld;
    logic [3:0] stall;
    logic       ovf;
  } stat_t;

  logic clock = 1'b0;
  logic reset;
  logic flush;
  logic flush1 = 1'b0;

  logic [3:0]   in_valid, in_rd_valid;
  logic [23:0]  in_preg, in_rob;
  logic [127:0] in_data;
  logic [1:0]   wb_valid, wb_rd_valid;
  logic [11:0]  wb_preg, wb_rob;
  logic [63:0]  wb_data;
  logic [3:0]   stall_pipe;
  logic         overflow;

  logic [3:0]   in1_valid, in1_rd_valid;
  logic [23:0]  in1_preg, in1_rob;
  logic [127:0] in1_data;
  logic [0:0]   wb1_valid, wb1_rd_valid;
  logic [5:0]   wb1_preg, wb1_rob;
  logic [31:0]  wb1_data;
  logic [3:0]   stall1;
  logic         overflow1;

  tup_t  q_main[$];
  tup_t  q_one[$];
  stat_t sq[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_fail = 0;

  wb_arbiter #(.NUM_PIPES(4), .NUM_WB(2)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_rd_valid(in_rd_valid), .in_preg(in_preg),
    .in_rob(in_rob), .in_data(in_data),
    .wb_valid(wb_valid), .wb_rd_valid(wb_rd_valid), .wb_preg(wb_preg),
    .wb_rob(wb_rob), .wb_data(wb_data),
    .stall_pipe(stall_pipe), .overflow(overflow)
  );

  wb_arbiter #(.NUM_PIPES(4), .NUM_WB(1)) dut1 (
    .clock(clock), .reset(reset), .flush(flush1),
    .in_valid(in1_valid), .in_rd_valid(in1_rd_valid), .in_preg(in1_preg),
    .in_rob(in1_rob), .in_data(in1_data),
    .wb_valid(wb1_valid), .wb_rd_valid(wb1_rd_valid), .wb_preg(wb1_preg),
    .wb_rob(wb1_rob), .wb_data(wb1_data),
    .stall_pipe(stall1), .overflow(overflow1)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic tup_t mk(input int port, input logic rdv, input logic [5:0] preg,
                              input logic [5:0] rob, input logic [31:0] data);
    return {2'(port), rdv, preg, rob, data};
  endfunction

  function automatic logic f_rdv(input int p, input int i);
    return ((p + i) % 2) == 0;
  endfunction
  function automatic logic [5:0] f_preg(input int p, input int i, input int tag);
    return 6'((tag * 16 + p * 4 + i) % 64);
  endfunction
  function automatic logic [5:0] f_rob(input int p, input int i, input int tag);
    return 6'((tag * 8 + i * 4 + p) % 64);
  endfunction
  function automatic logic [31:0] f_data(input int p, input int i, input int tag);
    return (32'(tag) << 24) | (32'(p) << 16) | 32'(i);
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clr_main();
    in_valid = '0; in_rd_valid = '0; in_preg = '0; in_rob = '0; in_data = '0;
  endtask
  task automatic clr_one();
    in1_valid = '0; in1_rd_valid = '0; in1_preg = '0; in1_rob = '0; in1_data = '0;
  endtask

  task automatic set_raw(input int p, input logic rdv, input logic [5:0] preg,
                         input logic [5:0] rob, input logic [31:0] data);
    in_valid[p] = 1'b1; in_rd_valid[p] = rdv;
    in_preg[p*6 +: 6] = preg; in_rob[p*6 +: 6] = rob; in_data[p*32 +: 32] = data;
  endtask
  task automatic set_main(input int p, input int i, input int tag);
    set_raw(p, f_rdv(p, i), f_preg(p, i, tag), f_rob(p, i, tag), f_data(p, i, tag));
  endtask
  task automatic set_one(input int p, input int i, input int tag);
    in1_valid[p] = 1'b1; in1_rd_valid[p] = f_rdv(p, i);
    in1_preg[p*6 +: 6] = f_preg(p, i, tag); in1_rob[p*6 +: 6] = f_rob(p, i, tag);
    in1_data[p*32 +: 32] = f_data(p, i, tag);
  endtask

  task automatic exp_main(input int port, input int p, input int i, input int tag);
    q_main.push_back(mk(port, f_rdv(p, i), f_preg(p, i, tag), f_rob(p, i, tag), f_data(p, i, tag)));
  endtask
  task automatic exp_one(input int p, input int i, input int tag);
    q_one.push_back(mk(0, f_rdv(p, i), f_preg(p, i, tag), f_rob(p, i, tag), f_data(p, i, tag)));
  endtask

  // Status expectations apply to the state after the next rising edge
  task automatic st_main(input int id, input logic [1:0] vld, input logic [3:0] stall, input logic ovf);
    stat_t s;
    s.cyc = cyc + 1; s.kind = 0; s.id = id; s.vld = vld; s.stall = stall; s.ovf = ovf;
    sq.push_back(s);
  endtask
  task automatic st_one(input int id, input logic [3:0] stall, input logic ovf);
    stat_t s;
    s.cyc = cyc + 1; s.kind = 1; s.id = id; s.vld = '0; s.stall = stall; s.ovf = ovf;
    sq.push_back(s);
  endtask
  task automatic st_drained(input int id);
    stat_t s;
    s.cyc = cyc + 1; s.kind = 2; s.id = id; s.vld = '0; s.stall = '0; s.ovf = 1'b0;
    sq.push_back(s);
  endtask

  // Monitor: the only process that updates the comparison counters
  always @(negedge clock) begin
    tup_t  got;
    tup_t  want;
    stat_t s;
    for (int k = 0; k < 2; k++) begin
      if (wb_valid[k]) begin
        got = mk(k, wb_rd_valid[k], wb_preg[k*6 +: 6], wb_rob[k*6 +: 6], wb_data[k*32 +: 32]);
        n_cmp++;
        if (q_main.size() == 0) begin
          n_fail++;
          $display("FAIL wb_main_unexpected cyc%0d: got %h required nothing", cyc, got);
        end else begin
          want = q_main.pop_front();
          if (got !== want) begin
            n_fail++;
            $display("FAIL wb_main_entry cyc%0d: got %h required %h", cyc, got, want);
          end
        end
      end
    end
    if (wb1_valid[0]) begin
      got = mk(0, wb1_rd_valid[0], wb1_preg, wb1_rob, wb1_data);
      n_cmp++;
      if (q_one.size() == 0) begin
        n_fail++;
        $display("FAIL wb_one_unexpected cyc%0d: got %h required nothing", cyc, got);
      end else begin
        want = q_one.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL wb_one_entry cyc%0d: got %h required %h", cyc, got, want);
        end
      end
    end
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      s = sq.pop_front();
      n_cmp++;
      if (s.cyc < cyc) begin
        n_fail++;
        $display("FAIL status_missed id%0d: checked at cyc%0d required cyc%0d", s.id, cyc, s.cyc);
      end else if (s.kind == 0) begin
        if ({wb_valid, stall_pipe, overflow} !== {s.vld, s.stall, s.ovf}) begin
          n_fail++;
          $display("FAIL status_main id%0d: got vld=%b stall=%b ovf=%b required vld=%b stall=%b ovf=%b",
                   s.id, wb_valid, stall_pipe, overflow, s.vld, s.stall, s.ovf);
        end
      end else if (s.kind == 1) begin
        if ({stall1, overflow1} !== {s.stall, s.ovf}) begin
          n_fail++;
          $display("FAIL status_one id%0d: got stall=%b ovf=%b required stall=%b ovf=%b",
                   s.id, stall1, overflow1, s.stall, s.ovf);
        end
      end else begin
        if (q_main.size() != 0 || q_one.size() != 0) begin
          n_fail++;
          $display("FAIL drained id%0d: got pending main=%0d one=%0d required 0/0",
                   s.id, q_main.size(), q_one.size());
        end
      end
    end
  end

  logic [3:0] fair_stall [6];
  logic [3:0] ovf_stall  [9];

  initial begin
    fair_stall = '{4'b0000, 4'b0000, 4'b1000, 4'b1001, 4'b1001, 4'b1001};
    ovf_stall  = '{4'b0000, 4'b0000, 4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
    reset = 1'b1; flush = 1'b0;
    clr_main(); clr_one();
    tick();
    // Reset state of both instances
    st_main(1, 2'b00, 4'b0000, 1'b0);
    st_one(2, 4'b0000, 1'b0);
    tick();
    reset = 1'b0;

    // Single completion on pipe 2, 1-cycle latency onto port 0
    set_raw(2, 1'b1, 6'd5, 6'd9, 32'hDEADBEEF);
    q_main.push_back(mk(0, 1'b1, 6'd5, 6'd9, 32'hDEADBEEF));
    st_main(3, 2'b01, 4'b0000, 1'b0);
    tick(); clr_main();
    // rd_valid=0 still occupies a port; rr moves to 0 after this
    set_raw(3, 1'b0, 6'd1, 6'd2, 32'h3333_0000);
    q_main.push_back(mk(0, 1'b0, 6'd1, 6'd2, 32'h3333_0000));
    st_main(4, 2'b01, 4'b0000, 1'b0);
    tick(); clr_main();
    st_main(5, 2'b00, 4'b0000, 1'b0);
    tick();

    // Contention: all four pipes at once with rr=0
    for (int p = 0; p < 4; p++) set_main(p, 0, 1);
    exp_main(0, 0, 0, 1); exp_main(1, 1, 0, 1);
    exp_main(0, 2, 0, 1); exp_main(1, 3, 0, 1);
    st_main(6, 2'b11, 4'b0000, 1'b0);
    tick(); clr_main();
    st_main(7, 2'b11, 4'b0000, 1'b0);
    tick();
    st_main(8, 2'b00, 4'b0000, 1'b0);
    tick();

    // Fairness on the single-port instance: pipes 0 and 3 every cycle
    for (int i = 0; i < 6; i++) begin exp_one(0, i, 2); exp_one(3, i, 2); end
    for (int i = 0; i < 6; i++) begin
      clr_one();
      set_one(0, i, 2); set_one(3, i, 2);
      st_one(10 + i, fair_stall[i], 1'b0);
      tick();
    end
    clr_one();
    repeat (6) tick();
    st_one(16, 4'b0000, 1'b0);
    tick();

    // Overflow on the single-port instance: pipe 1 fills, ninth result dropped
    for (int i = 0; i < 8; i++) begin exp_one(0, i, 3); exp_one(1, i, 3); end
    for (int i = 0; i < 9; i++) begin
      clr_one();
      if (i < 8) set_one(0, i, 3);
      set_one(1, i, 3);
      st_one(20 + i, ovf_stall[i], (i == 8));
      tick();
    end
    clr_one();
    repeat (7) tick();
    st_one(29, 4'b0000, 1'b1);
    tick();

    // Flush: build up backlog in every pipe, then flush with pipe 1 incoming
    for (int c = 0; c < 6; c++) begin
      if (c % 2 == 0) begin exp_main(0, 0, c / 2, 4); exp_main(1, 1, c / 2, 4); end
      else            begin exp_main(0, 2, c / 2, 4); exp_main(1, 3, c / 2, 4); end
    end
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < 4; p++) set_main(p, i, 4);
      st_main(30 + i, 2'b11, (i < 2) ? 4'b0000 : ((i == 2) ? 4'b1100 : 4'b1111), 1'b0);
      tick();
    end
    clr_main();
    flush = 1'b1;
    set_main(1, 9, 4);
    st_main(36, 2'b00, 4'b0000, 1'b0);
    tick();
    flush = 1'b0; clr_main();
    st_main(37, 2'b00, 4'b0000, 1'b0);
    tick();

    // Reset mid-drain, then a fresh completion with 1-cycle latency
    for (int c = 0; c < 4; c++) begin
      if (c % 2 == 0) begin exp_main(0, 0, c / 2, 5); exp_main(1, 1, c / 2, 5); end
      else            begin exp_main(0, 2, c / 2, 5); exp_main(1, 3, c / 2, 5); end
    end
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 4; p++) set_main(p, i, 5);
      st_main(40 + i, 2'b11, (i < 2) ? ((i == 0) ? 4'b0000 : 4'b0000) : ((i == 2) ? 4'b1100 : 4'b1111), 1'b0);
      tick();
    end
    clr_main();
    reset = 1'b1;
    st_main(44, 2'b00, 4'b0000, 1'b0);
    st_one(45, 4'b0000, 1'b0);
    tick();
    reset = 1'b0;
    set_main(3, 0, 6);
    exp_main(0, 3, 0, 6);
    st_main(46, 2'b01, 4'b0000, 1'b0);
    tick(); clr_main();
    st_main(47, 2'b00, 4'b0000, 1'b0);
    tick();
    st_drained(48);
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Sits directly downstream of the execution pipes. Collects completed results from NUM_PIPES pipes and drives NUM_WB register-file/ROB writeback ports.
- The pipes cannot be stalled once a uop is issued, so each pipe has a small FIFO that absorbs results when more pipes complete than there are writeback ports.
- Raises per-pipe stall hints toward issue so the FIFOs never overflow in correct operation.

Parameters:
- NUM_PIPES, 4, number of execution pipes feeding the block
- NUM_WB, 2, number of writeback ports per cycle (1 <= NUM_WB <= NUM_PIPES)
- DATA_W, 32, result width
- PREG_W, 6, physical register index width
- ROB_W, 6, ROB index width
- FIFO_DEPTH, 4, entries per pipe FIFO (power of two, >= 2)
- STALL_MARGIN, 2, stall_pipe[p] asserts when free entries <= STALL_MARGIN

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  mispredict flush; discards all buffered and incoming results
- in_valid  in  NUM_PIPES  pipe p produced a completion this cycle
- in_rd_valid  in  NUM_PIPES  completion writes a destination register
- in_preg  in  NUM_PIPES*PREG_W  destination physical register, pipe p at bits [p*PREG_W +: PREG_W]
- in_rob  in  NUM_PIPES*ROB_W  ROB index
- in_data  in  NUM_PIPES*DATA_W  result data
- wb_valid  out  NUM_WB  writeback port k valid
- wb_rd_valid  out  NUM_WB  port k writes a register
- wb_preg  out  NUM_WB*PREG_W  destination physical register
- wb_rob  out  NUM_WB*ROB_W  ROB index to mark complete
- wb_data  out  NUM_WB*DATA_W  result data
- stall_pipe  out  NUM_PIPES  issue must not send a new uop to pipe p
- overflow  out  1  sticky error: a completion was dropped because its FIFO was full

Behaviour:
- **Reset.** All FIFOs empty; wb_* = 0; overflow = 0; round-robin pointer rr = 0; stall_pipe = 0.
- **Candidates.** Each cycle, pipe p's candidate is its FIFO head if the FIFO is non-empty. Otherwise, if in_valid[p], the incoming entry is the candidate (bypass).
- **Arbitration.**
  - Scan pipes in order rr, rr+1, ... (mod NUM_PIPES) and grant up to NUM_WB pipes that have a candidate.
  - The g-th grant drives port g; unused ports are driven with wb_valid=0.
  - At most one entry per pipe is granted per cycle.
- **Latency.** wb_* are registered. A granted candidate appears on the ports on the next rising edge, so the minimum latency from in_valid to wb_valid is 1 cycle.
- **Pointer update.** If at least one grant occurs, rr moves to (last granted pipe + 1) mod NUM_PIPES. With no grants, rr holds.
- **FIFO update (per pipe).**
  - A granted head pops.
  - A non-bypassed incoming entry pushes.
  - Push and pop in the same cycle are both performed, so a full FIFO with a pop accepts the push.
  - A push into a full FIFO with no pop drops the entry and sets overflow=1. overflow clears only on reset.
- **Ordering.** Per-pipe results retire to writeback in arrival order. There is no ordering guarantee across pipes.
- **stall_pipe[p].** Combinational from the registered occupancy: (FIFO_DEPTH - count[p]) <= STALL_MARGIN.
- **flush.**
  - All FIFOs are emptied at the edge and incoming in_valid that cycle is ignored.
  - wb_valid is 0 on the following cycle.
  - rr and overflow are unaffected.
- **Reset mid-operation.** Same as the reset state; buffered results are lost.
- **Field ordering.** in_rd_valid=0 entries still occupy a port (the ROB must be told of completion); wb_rd_valid passes through unchanged.
- **Pointers.** FIFO pointers wrap modulo FIFO_DEPTH; count is in the range 0..FIFO_DEPTH.

Test Plan:
- Single completion: pipe 2 in_valid, preg=5, rob=9, data=0xDEADBEEF, FIFOs empty -> next cycle wb_valid=2'b01, port 0 carries preg 5, rob 9, 0xDEADBEEF; FIFO 2 stays empty.
- Contention: all 4 pipes valid in one cycle, rr=0 -> cycle+1 ports carry pipes 0,1; cycle+2 carry pipes 2,3; rr ends at 0; no data reordering.
- Fairness: pipes 0 and 3 valid every cycle, NUM_WB=1 -> grants alternate 0,3,0,3; neither pipe starves; stall_pipe rises once free entries <= 2.
- Overflow: hold NUM_WB grants away from pipe 1 (other pipes continuously valid) while pipe 1 sends 6 results, ignoring stall -> 5th result lands in the full FIFO; if no pop, overflow=1 and exactly 4 buffered entries later drain in order.
- Flush: 3 entries buffered in pipe 0, pipe 1 in_valid with flush=1 -> next cycle wb_valid=0, all counts 0, stall_pipe=0; pipe 1's entry never appears.
- Reset mid-drain: assert reset while FIFOs hold entries -> next cycle all outputs 0, overflow=0; a new completion afterwards emerges with 1-cycle latency.
